// File: rtl/obuffer4_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | obuffer4_if : MAC-array capture and drain handshake bundle         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface obuffer4_if #(
   parameter int DW = 16
) ();
   logic [4*DW-1:0] MAC_ODATA;
   logic [3:0]      MAC_OVALID;
   logic [4*DW-1:0] OUT_DATA;
   logic            OUT_VALID;
   logic            OUT_READY;
   logic            OVF;
   logic            BUSY;

   modport master (
      output MAC_ODATA, MAC_OVALID, OUT_READY,
      input  OUT_DATA, OUT_VALID, OVF, BUSY
   );

   modport slave (
      input  MAC_ODATA, MAC_OVALID, OUT_READY,
      output OUT_DATA, OUT_VALID, OVF, BUSY
   );
endinterface
`default_nettype wire

// File: rtl/obuffer4.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | obuffer4 : ping-pong tile buffer deskewing 4 row-skewed psum lanes |
// | into 64-bit words; OBUF_RELU_EN clamps negative lanes on drain.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module obuffer4 #(
   parameter int DW       = 16,
   parameter int TILE_LEN = 4
) (
   input  wire logic CLK,
   input  wire logic RSTN,
   obuffer4_if.slave bus
);
   localparam int            CW     = $clog2(TILE_LEN);
   localparam logic [CW-1:0] C_LAST = CW'(TILE_LEN - 1);

   logic [DW-1:0]         mem_q [2][4][TILE_LEN];
   logic [DW-1:0]         mem_d [2][4][TILE_LEN];
   logic [3:0]            wbank_q, wbank_d;
   logic [3:0][CW-1:0]    wcnt_q, wcnt_d;
   logic [1:0][3:0]       done_q, done_d;
   logic                  rbank_q, rbank_d;
   logic [CW-1:0]         rcnt_q, rcnt_d;
   logic                  ovf_q, ovf_d;

   logic [DW-1:0]         w_lane [4];
   logic                  w_out_valid;
   logic                  w_accept;
   logic                  w_release;
   logic [1:0]            w_bank_release;
   logic [3:0]            w_wr_en;
   logic [3:0]            w_drop;
   logic [4*DW-1:0]       w_out_data;
   logic                  w_busy;

   for (genvar r = 0; r < 4; r++) begin : g_lane
      assign w_lane[r] = bus.MAC_ODATA[(4*DW-1)-r*DW -: DW];
   end

   assign w_out_valid    = &done_q[rbank_q];
   assign w_accept       = w_out_valid && bus.OUT_READY;
   assign w_release      = w_accept && (rcnt_q == C_LAST);
   assign w_bank_release = {w_release && rbank_q, w_release && !rbank_q};

   // A row stalled on a full bank may write into it on the very cycle it is released.
   always_comb begin
      w_wr_en = '0;
      w_drop  = '0;
      for (int r = 0; r < 4; r++) begin
         if (bus.MAC_OVALID[r]) begin
            if (!done_q[wbank_q[r]][r] || w_bank_release[wbank_q[r]])
               w_wr_en[r] = 1'b1;
            else
               w_drop[r] = 1'b1;
         end
      end
   end

   always_comb begin
      mem_d   = mem_q;
      wbank_d = wbank_q;
      wcnt_d  = wcnt_q;
      done_d  = done_q;
      rbank_d = rbank_q;
      rcnt_d  = rcnt_q;
      ovf_d   = ovf_q | (|w_drop);

      if (w_accept) begin
         if (w_release) begin
            rcnt_d          = '0;
            rbank_d         = ~rbank_q;
            done_d[rbank_q] = '0;
         end else begin
            rcnt_d = rcnt_q + CW'(1);
         end
      end

      // Applied after the release so a completing write keeps its done bit.
      for (int r = 0; r < 4; r++) begin
         if (w_wr_en[r]) begin
            mem_d[wbank_q[r]][r][wcnt_q[r]] = w_lane[r];
            if (wcnt_q[r] == C_LAST) begin
               wcnt_d[r]               = '0;
               done_d[wbank_q[r]][r]   = 1'b1;
               wbank_d[r]              = ~wbank_q[r];
            end else begin
               wcnt_d[r] = wcnt_q[r] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         wbank_q <= '0;
         wcnt_q  <= '0;
         done_q  <= '0;
         rbank_q <= 1'b0;
         rcnt_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wbank_q <= wbank_d;
         wcnt_q  <= wcnt_d;
         done_q  <= done_d;
         rbank_q <= rbank_d;
         rcnt_q  <= rcnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // Gating with valid gives a defined zero word while storage is still unwritten.
   always_comb begin
      logic [DW-1:0] v;
      w_out_data = '0;
      v          = '0;
      for (int r = 0; r < 4; r++) begin
         v = mem_q[rbank_q][r][rcnt_q];
`ifdef OBUF_RELU_EN
         if (v[DW-1])
            v = '0;
`endif
         w_out_data[(4*DW-1)-r*DW -: DW] = v;
      end
      if (!w_out_valid)
         w_out_data = '0;
   end

   always_comb begin
      w_busy = (&done_q[0]) || (&done_q[1]);
      for (int r = 0; r < 4; r++) begin
         if (wcnt_q[r] != '0)
            w_busy = 1'b1;
      end
   end

   assign bus.OUT_DATA  = w_out_data;
   assign bus.OUT_VALID = w_out_valid;
   assign bus.OVF       = ovf_q;
   assign bus.BUSY      = w_busy;
endmodule
`default_nettype wire
